// File: rtl/axi_sram_arbiter_if.sv
// Single-beat AXI subset used on every port of the SRAM arbiter.
// manager: arbiter side facing a manager; mux: arbiter side facing the SRAM controller.
interface axi_bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [ID_W-1:0]     rid;
  logic [1:0]          rresp;
  logic                rlast;

  modport manager (
    input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arid, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rdata, rid, rresp, rlast
  );

  modport mux (
    output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arid, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi_sram_arbiter.sv
// Round-robin two-manager to one-satellite AXI arbiter in front of the SRAM controller.
// Optional saturating statistics counters are built when SRAM_ARB_STATS_EN is defined.
module axi_sram_arbiter #(
  parameter int unsigned INIT_PRIO = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic       clk,
  input  logic       nrst,
  axi_bus_if.manager m0_bif,
  axi_bus_if.manager m1_bif,
  axi_bus_if.mux     s_bif,
  output logic [1:0] grant_o
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0_o,
  output logic [CNT_W-1:0] grant_cnt1_o,
  output logic [CNT_W-1:0] conflict_cnt_o
`endif
);

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_WR_ADDR = 3'd1,
    ARB_WR_DATA = 3'd2,
    ARB_WR_RESP = 3'd3,
    ARB_RD_ADDR = 3'd4,
    ARB_RD_DATA = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   owner_q, owner_d;
  logic   req0, req1;
  logic   done;
  logic   active;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ARB_IDLE;
      prio_q  <= (INIT_PRIO != 0);
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    done    = 1'b0;
    req0    = m0_bif.awvalid | m0_bif.arvalid;
    req1    = m1_bif.awvalid | m1_bif.arvalid;
    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? prio_q : req1;
          state_d = (owner_d ? m1_bif.awvalid : m0_bif.awvalid) ? ARB_WR_ADDR : ARB_RD_ADDR;
        end
      end
      ARB_WR_ADDR: if (s_bif.awvalid && s_bif.awready) state_d = ARB_WR_DATA;
      ARB_WR_DATA: if (s_bif.wvalid && s_bif.wready) state_d = ARB_WR_RESP;
      ARB_WR_RESP: begin
        if (s_bif.bvalid && s_bif.bready) begin
          state_d = ARB_IDLE;
          done    = 1'b1;
        end
      end
      ARB_RD_ADDR: if (s_bif.arvalid && s_bif.arready) state_d = ARB_RD_DATA;
      ARB_RD_DATA: begin
        if (s_bif.rvalid && s_bif.rready && s_bif.rlast) begin
          state_d = ARB_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Completion hands priority to whichever manager did not own the bus.
    if (done) prio_d = ~owner_q;
  end

  always_comb begin
    s_bif.awvalid  = 1'b0;
    s_bif.awaddr   = '0;
    s_bif.awid     = '0;
    s_bif.wvalid   = 1'b0;
    s_bif.wdata    = '0;
    s_bif.wstrb    = '0;
    s_bif.bready   = 1'b0;
    s_bif.arvalid  = 1'b0;
    s_bif.araddr   = '0;
    s_bif.arid     = '0;
    s_bif.rready   = 1'b0;
    m0_bif.awready = 1'b0;
    m0_bif.wready  = 1'b0;
    m0_bif.bvalid  = 1'b0;
    m0_bif.bid     = '0;
    m0_bif.bresp   = '0;
    m0_bif.arready = 1'b0;
    m0_bif.rvalid  = 1'b0;
    m0_bif.rdata   = '0;
    m0_bif.rid     = '0;
    m0_bif.rresp   = '0;
    m0_bif.rlast   = 1'b0;
    m1_bif.awready = 1'b0;
    m1_bif.wready  = 1'b0;
    m1_bif.bvalid  = 1'b0;
    m1_bif.bid     = '0;
    m1_bif.bresp   = '0;
    m1_bif.arready = 1'b0;
    m1_bif.rvalid  = 1'b0;
    m1_bif.rdata   = '0;
    m1_bif.rid     = '0;
    m1_bif.rresp   = '0;
    m1_bif.rlast   = 1'b0;
    grant_o        = 2'b00;
    // Gating on nrst keeps both sides quiet for the whole reset cycle.
    active         = nrst && (state_q != ARB_IDLE);
    if (active) begin
      grant_o = owner_q ? 2'b10 : 2'b01;
      if (owner_q) begin
        s_bif.awaddr = m1_bif.awaddr;
        s_bif.awid   = m1_bif.awid;
        s_bif.wdata  = m1_bif.wdata;
        s_bif.wstrb  = m1_bif.wstrb;
        s_bif.araddr = m1_bif.araddr;
        s_bif.arid   = m1_bif.arid;
      end else begin
        s_bif.awaddr = m0_bif.awaddr;
        s_bif.awid   = m0_bif.awid;
        s_bif.wdata  = m0_bif.wdata;
        s_bif.wstrb  = m0_bif.wstrb;
        s_bif.araddr = m0_bif.araddr;
        s_bif.arid   = m0_bif.arid;
      end
      case (state_q)
        ARB_WR_ADDR: begin
          s_bif.awvalid = owner_q ? m1_bif.awvalid : m0_bif.awvalid;
          if (owner_q) m1_bif.awready = s_bif.awready;
          else         m0_bif.awready = s_bif.awready;
        end
        ARB_WR_DATA: begin
          s_bif.wvalid = owner_q ? m1_bif.wvalid : m0_bif.wvalid;
          if (owner_q) m1_bif.wready = s_bif.wready;
          else         m0_bif.wready = s_bif.wready;
        end
        ARB_WR_RESP: begin
          s_bif.bready = owner_q ? m1_bif.bready : m0_bif.bready;
          if (owner_q) begin
            m1_bif.bvalid = s_bif.bvalid;
            m1_bif.bid    = s_bif.bid;
            m1_bif.bresp  = s_bif.bresp;
          end else begin
            m0_bif.bvalid = s_bif.bvalid;
            m0_bif.bid    = s_bif.bid;
            m0_bif.bresp  = s_bif.bresp;
          end
        end
        ARB_RD_ADDR: begin
          s_bif.arvalid = owner_q ? m1_bif.arvalid : m0_bif.arvalid;
          if (owner_q) m1_bif.arready = s_bif.arready;
          else         m0_bif.arready = s_bif.arready;
        end
        ARB_RD_DATA: begin
          s_bif.rready = owner_q ? m1_bif.rready : m0_bif.rready;
          if (owner_q) begin
            m1_bif.rvalid = s_bif.rvalid;
            m1_bif.rdata  = s_bif.rdata;
            m1_bif.rid    = s_bif.rid;
            m1_bif.rresp  = s_bif.rresp;
            m1_bif.rlast  = s_bif.rlast;
          end else begin
            m0_bif.rvalid = s_bif.rvalid;
            m0_bif.rdata  = s_bif.rdata;
            m0_bif.rid    = s_bif.rid;
            m0_bif.rresp  = s_bif.rresp;
            m0_bif.rlast  = s_bif.rlast;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q, conf_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      conf_q <= '0;
    end else begin
      if (done && !owner_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (done && owner_q && (cnt1_q != '1))  cnt1_q <= cnt1_q + CNT_W'(1);
      if ((state_q == ARB_IDLE) && req0 && req1 && (conf_q != '1)) conf_q <= conf_q + CNT_W'(1);
    end
  end

  always_comb begin
    grant_cnt0_o   = cnt0_q;
    grant_cnt1_o   = cnt1_q;
    conflict_cnt_o = conf_q;
  end
`endif

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Scoreboard bench for axi_sram_arbiter with a single-beat SRAM satellite model.
module tb_axi_sram_arbiter;
  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  axi_bus_if m0_bus ();
  axi_bus_if m1_bus ();
  axi_bus_if s_bus ();

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] gcnt0, gcnt1, ccnt;
`endif

  axi_sram_arbiter #(.INIT_PRIO(0), .CNT_W(32)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .m0_bif (m0_bus),
    .m1_bif (m1_bus),
    .s_bif  (s_bus),
    .grant_o(grant)
`ifdef SRAM_ARB_STATS_EN
    ,
    .grant_cnt0_o  (gcnt0),
    .grant_cnt1_o  (gcnt1),
    .conflict_cnt_o(ccnt)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
  } exp_t;

  exp_t       rq0[$], rq1[$], bq0[$], bq1[$];
  logic [1:0] gq[$];
  time        t_ar_start[2], t_ar_hs[2], t_r_hs[2], t_b_hs[2], g_rise_t[2];
  logic [31:0] mem [logic [31:0]];

  localparam int HS_AW = 5, HS_W = 4, HS_B = 3, HS_AR = 2, HS_R = 1, HS_RV = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=absent required=present", name);
  endtask

  task automatic set_ar(input int mi, input logic v, input logic [31:0] a, input logic [3:0] id);
    if (mi == 0) begin m0_bus.arvalid = v; m0_bus.araddr = a; m0_bus.arid = id; end
    else         begin m1_bus.arvalid = v; m1_bus.araddr = a; m1_bus.arid = id; end
  endtask

  task automatic set_aw(input int mi, input logic v, input logic [31:0] a, input logic [3:0] id);
    if (mi == 0) begin m0_bus.awvalid = v; m0_bus.awaddr = a; m0_bus.awid = id; end
    else         begin m1_bus.awvalid = v; m1_bus.awaddr = a; m1_bus.awid = id; end
  endtask

  task automatic set_w(input int mi, input logic v, input logic [31:0] d, input logic [3:0] s);
    if (mi == 0) begin m0_bus.wvalid = v; m0_bus.wdata = d; m0_bus.wstrb = s; end
    else         begin m1_bus.wvalid = v; m1_bus.wdata = d; m1_bus.wstrb = s; end
  endtask

  task automatic set_rready(input int mi, input logic v);
    if (mi == 0) m0_bus.rready = v; else m1_bus.rready = v;
  endtask

  task automatic set_bready(input int mi, input logic v);
    if (mi == 0) m0_bus.bready = v; else m1_bus.bready = v;
  endtask

  function automatic logic [5:0] hs_vec(input int mi);
    if (mi == 0)
      return {m0_bus.awvalid & m0_bus.awready, m0_bus.wvalid & m0_bus.wready,
              m0_bus.bvalid & m0_bus.bready, m0_bus.arvalid & m0_bus.arready,
              m0_bus.rvalid & m0_bus.rready, m0_bus.rvalid};
    return {m1_bus.awvalid & m1_bus.awready, m1_bus.wvalid & m1_bus.wready,
            m1_bus.bvalid & m1_bus.bready, m1_bus.arvalid & m1_bus.arready,
            m1_bus.rvalid & m1_bus.rready, m1_bus.rvalid};
  endfunction

  task automatic wait_hs(input int mi, input int bitpos, input string name, output logic ok);
    logic [5:0] h;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      h = hs_vec(mi);
      if (h[bitpos]) begin ok = 1'b1; break; end
    end
    if (!ok) fail(name);
  endtask

  task automatic do_read(input int mi, input logic [31:0] addr, input logic [3:0] id,
                         input logic [31:0] exp_data, input int hold);
    logic ok;
    if (mi == 0) rq0.push_back('{exp_data, id}); else rq1.push_back('{exp_data, id});
    t_ar_start[mi] = $time;
    set_ar(mi, 1'b1, addr, id);
    set_rready(mi, hold == 0);
    wait_hs(mi, HS_AR, "ar_timeout", ok);
    t_ar_hs[mi] = $time;
    #1 set_ar(mi, 1'b0, '0, '0);
    if (!ok) return;
    if (hold > 0) begin
      wait_hs(mi, HS_RV, "rvalid_timeout", ok);
      if (!ok) return;
      repeat (hold) @(posedge clk);
      #1;
      chk("bp_grant_held", grant, (mi == 0) ? 2'b01 : 2'b10);
      set_rready(mi, 1'b1);
    end
    wait_hs(mi, HS_R, "r_timeout", ok);
    t_r_hs[mi] = $time;
    #1 set_rready(mi, 1'b0);
  endtask

  task automatic do_write(input int mi, input logic [31:0] addr, input logic [3:0] id,
                          input logic [31:0] data, input logic [3:0] strb);
    logic [5:0] h;
    logic       aw_done, w_done, ok;
    if (mi == 0) bq0.push_back('{32'h0, id}); else bq1.push_back('{32'h0, id});
    set_aw(mi, 1'b1, addr, id);
    set_w(mi, 1'b1, data, strb);
    set_bready(mi, 1'b1);
    aw_done = 1'b0;
    w_done  = 1'b0;
    for (int c = 0; c < 300 && !(aw_done && w_done); c++) begin
      @(posedge clk);
      h = hs_vec(mi);
      #1;
      if (h[HS_AW]) begin aw_done = 1'b1; set_aw(mi, 1'b0, '0, '0); end
      if (h[HS_W])  begin w_done  = 1'b1; set_w(mi, 1'b0, '0, '0); end
    end
    if (!(aw_done && w_done)) begin fail("aw_w_timeout"); return; end
    wait_hs(mi, HS_B, "b_timeout", ok);
    t_b_hs[mi] = $time;
    #1 set_bready(mi, 1'b0);
  endtask

  // SRAM satellite: always ready, one-cycle B/R response, cleared on nrst.
  initial begin : sat
    logic [31:0] wa, ra, old;
    logic [3:0]  wid, rid_l;
    logic        bset, bclr, rset, rclr;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.arready = 1'b0;
    s_bus.bvalid = 1'b0; s_bus.bid = '0; s_bus.bresp = '0;
    s_bus.rvalid = 1'b0; s_bus.rdata = '0; s_bus.rid = '0; s_bus.rresp = '0; s_bus.rlast = 1'b0;
    wa = '0; ra = '0; wid = '0; rid_l = '0;
    forever begin
      @(posedge clk);
      bset = 1'b0; bclr = 1'b0; rset = 1'b0; rclr = 1'b0;
      if (nrst) begin
        if (s_bus.awvalid && s_bus.awready) begin wa = s_bus.awaddr; wid = s_bus.awid; end
        if (s_bus.wvalid && s_bus.wready) begin
          old = mem.exists(wa) ? mem[wa] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (s_bus.wstrb[b]) old[8*b +: 8] = s_bus.wdata[8*b +: 8];
          mem[wa] = old;
          bset = 1'b1;
        end
        if (s_bus.bvalid && s_bus.bready) bclr = 1'b1;
        if (s_bus.arvalid && s_bus.arready) begin ra = s_bus.araddr; rid_l = s_bus.arid; rset = 1'b1; end
        if (s_bus.rvalid && s_bus.rready) rclr = 1'b1;
      end
      #1;
      if (!nrst) begin
        s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.arready = 1'b0;
        s_bus.bvalid = 1'b0; s_bus.rvalid = 1'b0; s_bus.rdata = '0; s_bus.rlast = 1'b0;
      end else begin
        s_bus.awready = 1'b1; s_bus.wready = 1'b1; s_bus.arready = 1'b1;
        if (bclr) s_bus.bvalid = 1'b0;
        if (bset) begin s_bus.bvalid = 1'b1; s_bus.bid = wid; s_bus.bresp = 2'b00; end
        if (rclr) begin s_bus.rvalid = 1'b0; s_bus.rdata = '0; s_bus.rlast = 1'b0; end
        if (rset) begin
          s_bus.rvalid = 1'b1; s_bus.rdata = mem.exists(ra) ? mem[ra] : 32'h0;
          s_bus.rid = rid_l; s_bus.rresp = 2'b00; s_bus.rlast = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (m0_bus.rvalid && m0_bus.rready) begin
      if (rq0.size() == 0) fail("m0_r_unexpected");
      else begin
        e = rq0.pop_front();
        chk("m0_rdata", m0_bus.rdata, e.data);
        chk("m0_rid", m0_bus.rid, e.id);
        chk("m0_rresp_rlast", {m0_bus.rresp, m0_bus.rlast}, 3'b001);
      end
    end
    if (m1_bus.rvalid && m1_bus.rready) begin
      if (rq1.size() == 0) fail("m1_r_unexpected");
      else begin
        e = rq1.pop_front();
        chk("m1_rdata", m1_bus.rdata, e.data);
        chk("m1_rid", m1_bus.rid, e.id);
        chk("m1_rresp_rlast", {m1_bus.rresp, m1_bus.rlast}, 3'b001);
      end
    end
    if (m0_bus.bvalid && m0_bus.bready) begin
      if (bq0.size() == 0) fail("m0_b_unexpected");
      else begin e = bq0.pop_front(); chk("m0_bid_bresp", {m0_bus.bid, m0_bus.bresp}, {e.id, 2'b00}); end
    end
    if (m1_bus.bvalid && m1_bus.bready) begin
      if (bq1.size() == 0) fail("m1_b_unexpected");
      else begin e = bq1.pop_front(); chk("m1_bid_bresp", {m1_bus.bid, m1_bus.bresp}, {e.id, 2'b00}); end
    end
  end

  logic [1:0] g_prev = 2'b00;
  always @(negedge clk) begin
    if (grant != 2'b10)
      chk("m1_isolated", {m1_bus.awready, m1_bus.wready, m1_bus.bvalid, m1_bus.arready, m1_bus.rvalid}, 5'b0);
    if (grant != 2'b01)
      chk("m0_isolated", {m0_bus.awready, m0_bus.wready, m0_bus.bvalid, m0_bus.arready, m0_bus.rvalid}, 5'b0);
    if (g_prev == 2'b00 && grant != 2'b00) begin
      if (gq.size() == 0) fail("grant_unexpected");
      else chk("grant_order", grant, gq.pop_front());
      g_rise_t[grant[1]] = $time;
    end
    g_prev = grant;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic ok;
    m0_bus.awvalid = 0; m0_bus.awaddr = '0; m0_bus.awid = '0; m0_bus.wvalid = 0; m0_bus.wdata = '0;
    m0_bus.wstrb = '0; m0_bus.bready = 0; m0_bus.arvalid = 0; m0_bus.araddr = '0; m0_bus.arid = '0;
    m0_bus.rready = 0;
    m1_bus.awvalid = 0; m1_bus.awaddr = '0; m1_bus.awid = '0; m1_bus.wvalid = 0; m1_bus.wdata = '0;
    m1_bus.wstrb = '0; m1_bus.bready = 0; m1_bus.arvalid = 0; m1_bus.araddr = '0; m1_bus.arid = '0;
    m1_bus.rready = 0;
    mem[32'h1000_0040] = 32'hDEAD_BEEF;
    mem[32'h1000_0100] = 32'h1111_0000;
    mem[32'h1000_0104] = 32'h2222_0000;
    mem[32'h1000_0108] = 32'h3333_0000;
    mem[32'h1000_010C] = 32'h4444_0000;
    mem[32'h1000_0020] = 32'h0BAD_C0DE;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", grant, 2'b00);
    chk("reset_s_out", {s_bus.awvalid, s_bus.wvalid, s_bus.bready, s_bus.arvalid, s_bus.rready,
                        s_bus.awaddr, s_bus.araddr, s_bus.wdata}, '0);
`ifdef SRAM_ARB_STATS_EN
    chk("reset_counters", {gcnt0, gcnt1, ccnt}, '0);
`endif
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Contention right after reset: alternating 01,10,01,10.
    gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      begin
        do_read(0, 32'h1000_0100, 4'd1, 32'h1111_0000, 0);
        do_read(0, 32'h1000_0108, 4'd2, 32'h3333_0000, 0);
      end
      begin
        do_read(1, 32'h1000_0104, 4'd8, 32'h2222_0000, 0);
        do_read(1, 32'h1000_010C, 4'd9, 32'h4444_0000, 0);
      end
    join
`ifdef SRAM_ARB_STATS_EN
    chk("stats_contention", {gcnt0, gcnt1, ccnt}, {32'd2, 32'd2, 32'd3});
`endif

    // Single read with one-cycle arbitration latency.
    gq.push_back(2'b01);
    do_read(0, 32'h1000_0040, 4'd3, 32'hDEAD_BEEF, 0);
    chk("read_latency", t_ar_hs[0] - t_ar_start[0], 64'd19);
    chk("grant_idle_after_read", grant, 2'b00);

    // Single write from m1 then read-back from m0.
    gq.push_back(2'b10);
    do_write(1, 32'h1000_0008, 4'd5, 32'h1234_5678, 4'hF);
    gq.push_back(2'b01);
    do_read(0, 32'h1000_0008, 4'd2, 32'h1234_5678, 0);

    // m1 issues write and read together: write first, read after B.
    gq.push_back(2'b10); gq.push_back(2'b10);
    fork
      do_write(1, 32'h1000_0010, 4'd6, 32'hAABB_CCDD, 4'hF);
      do_read(1, 32'h1000_0010, 4'd7, 32'hAABB_CCDD, 0);
    join
    chk("mixed_read_after_b", t_ar_hs[1] > t_b_hs[1], 1'b1);

    // Backpressure on m0 R; m1 waits and is granted one cycle after the R handshake.
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      do_read(0, 32'h1000_0040, 4'd4, 32'hDEAD_BEEF, 5);
      begin
        repeat (3) @(posedge clk);
        #1;
        do_read(1, 32'h1000_0104, 4'd10, 32'h2222_0000, 0);
      end
    join
    chk("bp_m1_grant_delay", g_rise_t[1] - t_r_hs[0], 64'd15);

    // Reset while in the write-data phase.
    gq.push_back(2'b01);
    set_aw(0, 1'b1, 32'h1000_0020, 4'd2);
    set_w(0, 1'b1, 32'hCAFE_F00D, 4'hF);
    wait_hs(0, HS_AW, "rst_aw_timeout", ok);
    #1;
    nrst = 1'b0;
    set_aw(0, 1'b0, '0, '0);
    set_w(0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_s_valids", {s_bus.awvalid, s_bus.wvalid, s_bus.bready, s_bus.arvalid, s_bus.rready}, 5'b0);
    chk("midrst_m0_out", {m0_bus.awready, m0_bus.wready, m0_bus.bvalid, m0_bus.arready, m0_bus.rvalid}, 5'b0);
`ifdef SRAM_ARB_STATS_EN
    chk("midrst_counters", {gcnt0, gcnt1, ccnt}, '0);
`endif
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    gq.push_back(2'b01);
    do_read(0, 32'h1000_0020, 4'd1, 32'h0BAD_C0DE, 0);
`ifdef SRAM_ARB_STATS_EN
    chk("stats_final", {gcnt0, gcnt1, ccnt}, {32'd1, 32'd0, 32'd0});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", rq0.size() + rq1.size() + bq0.size() + bq1.size() + gq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
